// File: rtl/ccff_loader.sv
// Streams 32-bit bitstream words MSB-first into a configuration flip-flop chain,
// and can run a walking-one integrity test on the chain.
module ccff_loader #(
    parameter int BITSTREAM_SIZE = 29696,
    parameter int WORD_TIMEOUT   = 1024
) (
    input  logic                                  prog_clk,
    input  logic                                  pReset,
    input  logic                                  start_load,
    input  logic                                  start_test,
    input  logic                                  abort,
    input  logic [31:0]                           word_data,
    input  logic                                  word_valid,
    output logic                                  word_ready,
    output logic                                  ccff_head,
    output logic                                  ccff_shift_en,
    input  logic                                  ccff_tail,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  error,
    output logic [$clog2(BITSTREAM_SIZE+2)-1:0]   bit_count
);

    localparam int CW = $clog2(BITSTREAM_SIZE + 2);
    localparam int TW = $clog2(WORD_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_BIT     = CW'(BITSTREAM_SIZE - 1);
    localparam logic [CW-1:0] FULL_COUNT   = CW'(BITSTREAM_SIZE);
    localparam logic [CW-1:0] POST_COUNT   = CW'(BITSTREAM_SIZE + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(WORD_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, TEST, DONE, ERR} state_t;

    state_t          r_state;
    logic [31:0]     r_shreg;
    logic [5:0]      r_bitsLeft;
    logic [CW-1:0]   r_bitCount;
    logic [TW-1:0]   r_timeout;

    logic            w_haveBit;
    logic            w_testShift;
    logic            w_accept;

    // The bit on ccff_head is always the MSB of the shift register, so a word
    // accepted while the last bit is going out refills it without a bubble.
    assign w_haveBit   = (r_state == LOAD) && (r_bitsLeft != 6'd0);
    assign w_testShift = (r_state == TEST) && (r_bitCount <= FULL_COUNT);
    assign word_ready  = (r_state == LOAD) &&
                         ((r_bitsLeft == 6'd0) ||
                          ((r_bitsLeft == 6'd1) && (r_bitCount != LAST_BIT)));
    assign w_accept    = word_valid && word_ready;

    assign ccff_shift_en = w_haveBit || w_testShift;
    assign ccff_head     = (w_haveBit && r_shreg[31]) ||
                           (w_testShift && (r_bitCount == '0));
    assign busy      = (r_state == LOAD) || (r_state == TEST);
    assign done      = (r_state == DONE);
    assign error     = (r_state == ERR);
    assign bit_count = r_bitCount;

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_bitsLeft <= 6'd0;
            r_bitCount <= '0;
            r_timeout  <= '0;
        end else if (abort) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_bitsLeft <= 6'd0;
            r_timeout  <= '0;
        end else begin
            case (r_state)
                IDLE, DONE, ERR: begin
                    if (start_load) begin
                        r_state    <= LOAD;
                        r_shreg    <= '0;
                        r_bitsLeft <= 6'd0;
                        r_bitCount <= '0;
                        r_timeout  <= '0;
                    end else if (start_test) begin
                        r_state    <= TEST;
                        r_bitCount <= '0;
                    end
                end
                LOAD: begin
                    if (w_haveBit) begin
                        r_bitCount <= r_bitCount + CW'(1);
                        if (r_bitCount == LAST_BIT) begin
                            r_state    <= DONE;
                            r_shreg    <= '0;
                            r_bitsLeft <= 6'd0;
                        end else if (w_accept) begin
                            r_shreg    <= word_data;
                            r_bitsLeft <= 6'd32;
                            r_timeout  <= '0;
                        end else begin
                            r_shreg    <= {r_shreg[30:0], 1'b0};
                            r_bitsLeft <= r_bitsLeft - 6'd1;
                        end
                    end else if (w_accept) begin
                        r_shreg    <= word_data;
                        r_bitsLeft <= 6'd32;
                        r_timeout  <= '0;
                    end else begin
                        r_timeout <= r_timeout + TW'(1);
                        if (r_timeout == TIMEOUT_LAST) begin
                            r_state <= ERR;
                        end
                    end
                end
                TEST: begin
                    // The walking one must reach the tail after exactly
                    // BITSTREAM_SIZE shifts and be gone one shift later.
                    if (w_testShift) begin
                        r_bitCount <= r_bitCount + CW'(1);
                    end
                    if ((r_bitCount == FULL_COUNT) && !ccff_tail) begin
                        r_state <= ERR;
                    end else if (r_bitCount == POST_COUNT) begin
                        r_state <= ccff_tail ? ERR : DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_loader.sv
// Self-checking bench for ccff_loader: a 64-bit instance with a chain model and
// a 40-bit instance for truncation, checked against a word-stream reference.
module tb_ccff_loader;

    localparam int SIZE_A = 64;
    localparam int SIZE_B = 40;
    localparam int TMO_A  = 16;

    logic        prog_clk = 1'b0;
    logic        pReset = 1'b0;
    logic        startLoad = 1'b0;
    logic        startTest = 1'b0;
    logic        abortP = 1'b0;
    logic        wordValid = 1'b0;
    logic        chainClr = 1'b0;
    logic [31:0] wordData = '0;
    int          sel = 0;
    int          chainLen = 64;
    int          checks = 0;
    int          passes = 0;

    logic        readyA, headA, shenA, busyA, doneA, errorA, tailA;
    logic [6:0]  bcA;
    logic        readyB, headB, shenB, busyB, doneB, errorB;
    logic [5:0]  bcB;
    logic        curReady, curHead, curShen, curBusy, curDone, curError;
    logic [6:0]  curBc;
    logic [127:0] chainReg;

    logic        obsBits[$];
    logic        expBits[$];
    logic [31:0] srcWords[$];
    int          srcDelay[$];
    int          obsBubbles, obsFiller, obsEnd, obsStartCount;
    logic        obsEndReady;

    always #5 prog_clk = ~prog_clk;

    ccff_loader #(.BITSTREAM_SIZE(SIZE_A), .WORD_TIMEOUT(TMO_A)) dutA (
        .prog_clk(prog_clk), .pReset(pReset),
        .start_load(startLoad && sel == 0), .start_test(startTest && sel == 0),
        .abort(abortP && sel == 0), .word_data(wordData),
        .word_valid(wordValid && sel == 0), .word_ready(readyA),
        .ccff_head(headA), .ccff_shift_en(shenA), .ccff_tail(tailA),
        .busy(busyA), .done(doneA), .error(errorA), .bit_count(bcA));

    ccff_loader #(.BITSTREAM_SIZE(SIZE_B)) dutB (
        .prog_clk(prog_clk), .pReset(pReset),
        .start_load(startLoad && sel == 1), .start_test(startTest && sel == 1),
        .abort(abortP && sel == 1), .word_data(wordData),
        .word_valid(wordValid && sel == 1), .word_ready(readyB),
        .ccff_head(headB), .ccff_shift_en(shenB), .ccff_tail(1'b0),
        .busy(busyB), .done(doneB), .error(errorB), .bit_count(bcB));

    assign curReady = (sel == 1) ? readyB : readyA;
    assign curHead  = (sel == 1) ? headB  : headA;
    assign curShen  = (sel == 1) ? shenB  : shenA;
    assign curBusy  = (sel == 1) ? busyB  : busyA;
    assign curDone  = (sel == 1) ? doneB  : doneA;
    assign curError = (sel == 1) ? errorB : errorA;
    assign curBc    = (sel == 1) ? {1'b0, bcB} : bcA;

    // Zero-initialised shift-register chain of selectable length on instance A.
    always @(posedge prog_clk or negedge pReset) begin
        if (!pReset) chainReg <= '0;
        else if (chainClr) chainReg <= '0;
        else if (shenA) chainReg <= {chainReg[126:0], headA};
    end
    assign tailA = chainReg[7'(chainLen - 1)];

    // Reference stream: every word MSB first, cut off after size bits.
    task automatic buildExpected(input int size);
        expBits.delete();
        foreach (srcWords[w])
            for (int b = 31; b >= 0; b--)
                if (expBits.size() < size) expBits.push_back(srcWords[w][b]);
    endtask

    function automatic int streamErrors();
        int bad = 0;
        foreach (expBits[i])
            if (i >= obsBits.size() || obsBits[i] !== expBits[i]) bad++;
        return bad;
    endfunction

    // Drives one load and records what the chain saw; obsEnd: 1 done, 2 error,
    // 3 aborted, 4 idle, 0 cycle budget expired.
    task automatic runLoad(input int abortAt);
        int idx = 0;
        int hold;
        logic v;
        obsBits.delete();
        obsBubbles = 0; obsFiller = 0; obsEnd = 0;
        @(negedge prog_clk); startLoad = 1'b1;
        @(negedge prog_clk); startLoad = 1'b0;
        obsStartCount = int'(curBc);
        hold = srcDelay[0];
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!curBusy) begin
                obsEnd = curDone ? 1 : (curError ? 2 : 4);
                break;
            end
            if (curShen) obsBits.push_back(curHead);
            else begin
                if (obsBits.size() > 0) obsBubbles++;
                if (curHead) obsFiller++;
            end
            if (abortAt >= 0 && int'(curBc) == abortAt) begin
                wordValid = 1'b0; abortP = 1'b1;
                @(negedge prog_clk); abortP = 1'b0;
                obsEnd = 3;
                break;
            end
            if (hold > 0) begin v = 1'b0; hold--; end
            else v = (idx < srcWords.size());
            wordValid = v;
            wordData = v ? srcWords[idx] : $urandom;
            if (v && curReady) begin
                idx++;
                hold = (idx < srcWords.size() && srcDelay[idx] > 0) ? 31 + srcDelay[idx] : 0;
            end
            @(negedge prog_clk);
        end
        wordValid = 1'b0;
        obsEndReady = curReady;
    endtask

    task automatic setWords(input int n, input int gapWord, input int gap);
        srcWords.delete(); srcDelay.delete();
        for (int i = 0; i < n; i++) begin
            srcWords.push_back($urandom);
            srcDelay.push_back(i == gapWord ? gap : 0);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge prog_clk);
        startLoad = 1'b1;
        @(negedge prog_clk);
        checks++; if (busyA !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busyA); else passes++;
        checks++; if ({doneA, errorA, readyA} !== 3'b000) $display("[TB] FAIL reset_flags: got %b expected 000", {doneA, errorA, readyA}); else passes++;
        checks++; if ({shenA, headA} !== 2'b00) $display("[TB] FAIL reset_chain: got %b expected 00", {shenA, headA}); else passes++;
        checks++; if (bcA !== 7'd0) $display("[TB] FAIL reset_count: got %0d expected 0", bcA); else passes++;
        startLoad = 1'b0;
        pReset = 1'b1;
        @(negedge prog_clk);
    endtask

    task automatic test_back_to_back();
        srcWords.delete(); srcDelay.delete();
        srcWords.push_back(32'hA5A5_0001); srcWords.push_back(32'h8000_00FF);
        srcDelay.push_back(0); srcDelay.push_back(0);
        buildExpected(SIZE_A);
        runLoad(-1);
        checks++; if (obsEnd !== 1) $display("[TB] FAIL b2b_end: got %0d expected 1", obsEnd); else passes++;
        checks++; if (obsBits.size() !== 64) $display("[TB] FAIL b2b_shifts: got %0d expected 64", obsBits.size()); else passes++;
        checks++; if (obsBubbles !== 0) $display("[TB] FAIL b2b_bubbles: got %0d expected 0", obsBubbles); else passes++;
        checks++; if (streamErrors() !== 0) $display("[TB] FAIL b2b_stream: got %0d wrong bits expected 0", streamErrors()); else passes++;
        checks++; if (bcA !== 7'd64 || doneA !== 1'b1) $display("[TB] FAIL b2b_final: got count %0d done %b expected 64 1", bcA, doneA); else passes++;
    endtask

    task automatic test_truncate();
        sel = 1;
        setWords(2, -1, 0);
        buildExpected(SIZE_B);
        runLoad(-1);
        checks++; if (obsBits.size() !== 40) $display("[TB] FAIL trunc_shifts: got %0d expected 40", obsBits.size()); else passes++;
        checks++; if (streamErrors() !== 0) $display("[TB] FAIL trunc_stream: got %0d wrong bits expected 0", streamErrors()); else passes++;
        checks++; if (obsEndReady !== 1'b0 || doneB !== 1'b1) $display("[TB] FAIL trunc_done: got ready %b done %b expected 0 1", obsEndReady, doneB); else passes++;
        checks++; if (bcB !== 6'd40) $display("[TB] FAIL trunc_count: got %0d expected 40", bcB); else passes++;
        sel = 0;
    endtask

    task automatic test_gap();
        setWords(3, 1, 5);
        buildExpected(SIZE_A);
        runLoad(-1);
        checks++; if (obsBubbles !== 5) $display("[TB] FAIL gap_bubbles: got %0d expected 5", obsBubbles); else passes++;
        checks++; if (obsBits.size() !== 64 || obsFiller !== 0) $display("[TB] FAIL gap_shifts: got %0d filler %0d expected 64 0", obsBits.size(), obsFiller); else passes++;
        checks++; if (streamErrors() !== 0 || obsEnd !== 1) $display("[TB] FAIL gap_stream: got %0d wrong end %0d expected 0 1", streamErrors(), obsEnd); else passes++;
    endtask

    task automatic test_timeout();
        setWords(1, -1, 0);
        runLoad(-1);
        checks++; if (obsEnd !== 2) $display("[TB] FAIL tmo_end: got %0d expected 2", obsEnd); else passes++;
        checks++; if (obsBubbles !== TMO_A) $display("[TB] FAIL tmo_bubbles: got %0d expected %0d", obsBubbles, TMO_A); else passes++;
        checks++; if (errorA !== 1'b1 || busyA !== 1'b0) $display("[TB] FAIL tmo_flags: got error %b busy %b expected 1 0", errorA, busyA); else passes++;
        setWords(2, -1, 0);
        buildExpected(SIZE_A);
        runLoad(-1);
        checks++; if (errorA !== 1'b0 || doneA !== 1'b1 || streamErrors() !== 0) $display("[TB] FAIL tmo_recover: got error %b done %b bad %0d expected 0 1 0", errorA, doneA, streamErrors()); else passes++;
    endtask

    task automatic test_chain(input int len);
        int shifts = 0, ones = 0;
        logic t64 = 1'bx, t65 = 1'bx, firstHead = 1'bx;
        @(negedge prog_clk); chainClr = 1'b1; chainLen = len;
        @(negedge prog_clk); chainClr = 1'b0; startTest = 1'b1;
        @(negedge prog_clk); startTest = 1'b0;
        for (int cyc = 0; cyc < 300 && busyA; cyc++) begin
            if (shenA) begin
                if (shifts == 0) firstHead = headA;
                shifts++;
                if (headA) ones++;
            end
            if (bcA == 7'd64) t64 = tailA;
            if (bcA == 7'd65) t65 = tailA;
            @(negedge prog_clk);
        end
        if (len == 64) begin
            checks++; if (t64 !== 1'b1 || t65 !== 1'b0) $display("[TB] FAIL test_tail: got %b/%b expected 1/0", t64, t65); else passes++;
            checks++; if (shifts !== 65 || ones !== 1 || firstHead !== 1'b1) $display("[TB] FAIL test_pattern: got shifts %0d ones %0d first %b expected 65 1 1", shifts, ones, firstHead); else passes++;
            checks++; if (doneA !== 1'b1 || bcA !== 7'd65 || busyA !== 1'b0) $display("[TB] FAIL test_done: got done %b count %0d busy %b expected 1 65 0", doneA, bcA, busyA); else passes++;
        end else begin
            checks++; if (errorA !== 1'b1 || busyA !== 1'b0 || doneA !== 1'b0) $display("[TB] FAIL test_short: got error %b busy %b done %b expected 1 0 0", errorA, busyA, doneA); else passes++;
        end
        chainLen = 64;
    endtask

    task automatic test_abort();
        setWords(3, -1, 0);
        runLoad(17);
        checks++; if (obsEnd !== 3 || busyA !== 1'b0 || shenA !== 1'b0) $display("[TB] FAIL abort_idle: got end %0d busy %b shen %b expected 3 0 0", obsEnd, busyA, shenA); else passes++;
        checks++; if (bcA !== 7'd17 || doneA !== 1'b0 || errorA !== 1'b0) $display("[TB] FAIL abort_hold: got count %0d done %b error %b expected 17 0 0", bcA, doneA, errorA); else passes++;
        abortP = 1'b1; startLoad = 1'b1;
        @(negedge prog_clk); abortP = 1'b0; startLoad = 1'b0;
        checks++; if (busyA !== 1'b0) $display("[TB] FAIL abort_priority: got busy %b expected 0", busyA); else passes++;
        setWords(2, -1, 0);
        buildExpected(SIZE_A);
        runLoad(-1);
        checks++; if (obsStartCount !== 0) $display("[TB] FAIL abort_restart: got count %0d expected 0", obsStartCount); else passes++;
        checks++; if (streamErrors() !== 0 || obsBits.size() !== 64 || doneA !== 1'b1) $display("[TB] FAIL abort_reload: got bad %0d shifts %0d done %b expected 0 64 1", streamErrors(), obsBits.size(), doneA); else passes++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int gap = $urandom_range(0, 6);
            setWords(2 + $urandom_range(0, 1), 1, gap);
            srcDelay[0] = $urandom_range(0, 3);
            buildExpected(SIZE_A);
            runLoad(-1);
            checks++; if (obsBubbles !== gap || obsBits.size() !== 64) $display("[TB] FAIL rand_timing%0d: got bubbles %0d shifts %0d expected %0d 64", it, obsBubbles, obsBits.size(), gap); else passes++;
            checks++; if (streamErrors() !== 0 || obsEnd !== 1) $display("[TB] FAIL rand_stream%0d: got bad %0d end %0d expected 0 1", it, streamErrors(), obsEnd); else passes++;
        end
    endtask

    task automatic test_reset_midtest();
        @(negedge prog_clk); startTest = 1'b1;
        @(negedge prog_clk); startTest = 1'b0;
        repeat (5) @(negedge prog_clk);
        startLoad = 1'b1;
        @(negedge prog_clk); startLoad = 1'b0;
        checks++; if (bcA !== 7'd6 || readyA !== 1'b0 || shenA !== 1'b1) $display("[TB] FAIL ignore_start: got count %0d ready %b shen %b expected 6 0 1", bcA, readyA, shenA); else passes++;
        @(posedge prog_clk); #2 pReset = 1'b0;
        #1;
        checks++; if ({busyA, doneA, errorA, readyA, shenA, headA} !== 6'b0 || bcA !== 7'd0) $display("[TB] FAIL async_reset: got %b count %0d expected 000000 0", {busyA, doneA, errorA, readyA, shenA, headA}, bcA); else passes++;
        repeat (2) @(negedge prog_clk);
        pReset = 1'b1;
        repeat (4) @(negedge prog_clk);
        checks++; if (busyA !== 1'b0 || shenA !== 1'b0 || bcA !== 7'd0) $display("[TB] FAIL no_resume: got busy %b shen %b count %0d expected 0 0 0", busyA, shenA, bcA); else passes++;
    endtask

    task automatic test_both_starts();
        @(negedge prog_clk); startLoad = 1'b1; startTest = 1'b1;
        @(negedge prog_clk); startLoad = 1'b0; startTest = 1'b0;
        checks++; if (busyA !== 1'b1 || readyA !== 1'b1 || shenA !== 1'b0) $display("[TB] FAIL both_starts: got busy %b ready %b shen %b expected 1 1 0", busyA, readyA, shenA); else passes++;
        abortP = 1'b1;
        @(negedge prog_clk); abortP = 1'b0;
        checks++; if (busyA !== 1'b0 || readyA !== 1'b0) $display("[TB] FAIL both_abort: got busy %b ready %b expected 0 0", busyA, readyA); else passes++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_truncate();
        test_gap();
        test_timeout();
        test_chain(64);
        test_chain(63);
        test_abort();
        test_random();
        test_reset_midtest();
        test_both_starts();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
